// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: FSM states, memory-op kinds,
// access widths, and the store byte-enable helper.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2,
        MEM_DONE = 2'd3
    } mem_state_e;

    localparam logic [1:0] DMEM_NONE  = 2'b00;
    localparam logic [1:0] DMEM_LOAD  = 2'b01;
    localparam logic [1:0] DMEM_STORE = 2'b10;

    localparam logic [1:0] IO_BYTE = 2'b00;
    localparam logic [1:0] IO_HALF = 2'b01;
    localparam logic [1:0] IO_WORD = 2'b10;

    // Half accesses are halfword aligned, so only off[1] picks the lane pair.
    function automatic logic [3:0] store_strobe(input logic [1:0] io, input logic [1:0] off);
        logic [3:0] strb;
        case (io)
            IO_BYTE: strb = 4'b0001 << off;
            IO_HALF: strb = off[1] ? 4'b1100 : 4'b0011;
            IO_WORD: strb = 4'b1111;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// DCache request/response bundle between the memory stage (master) and the
// data cache (slave).
interface mem_stage_if #(
    parameter int WORD = 32
);
    logic              dc_req;
    logic              dc_we;
    logic [WORD-1:0]   dc_addr;
    logic [WORD/8-1:0] dc_wstrb;
    logic [WORD-1:0]   dc_wdata;
    logic              dc_addr_ok;
    logic              dc_data_ok;
    logic [WORD-1:0]   dc_rdata;

    modport master (
        output dc_req, dc_we, dc_addr, dc_wstrb, dc_wdata,
        input  dc_addr_ok, dc_data_ok, dc_rdata
    );

    modport slave (
        input  dc_req, dc_we, dc_addr, dc_wstrb, dc_wdata,
        output dc_addr_ok, dc_data_ok, dc_rdata
    );
endinterface

// File: rtl/mem_load_align.sv
// Extracts the addressed byte/half/word from a DCache read word and
// sign- or zero-extends it to the datapath width.
module mem_load_align
    import mem_stage_pkg::*;
#(
    parameter int WORD = 32
) (
    input  logic [WORD-1:0] rdata_i,
    input  logic [1:0]      off_i,
    input  logic [1:0]      io_i,
    input  logic            sign_i,
    output logic [WORD-1:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata_i[{off_i, 3'b000} +: 8];
        half_v = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (io_i)
            IO_BYTE: data_o = {{(WORD-8){sign_i & byte_v[7]}}, byte_v};
            IO_HALF: data_o = {{(WORD-16){sign_i & half_v[15]}}, half_v};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: finishes the EX multiply, runs the DCache handshake for
// loads/stores, aligns load data and stalls upstream while an access is open.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int WORD    = 32,
    parameter int REG_LOG = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD-1:0]      pc_in,
    input  logic [WORD-1:0]      inst_in,
    input  logic [7:0]           ctrl_in,
    input  logic                 cal_sel_in,
    input  logic [WORD-1:0]      alu_res_in,
    input  logic [3*REG_LOG-1:0] rs_in,
    input  logic                 sign_in,
    input  logic [3*WORD-1:0]    mul_tmp_in,
    input  logic [1:0]           is_dmem_in,
    input  logic [1:0]           io_info_in,
    input  logic [WORD-1:0]      data_to_t_in,
    mem_stage_if.master          dc,
    output logic                 stall_from_DCache,
    output logic [WORD-1:0]      pc_out,
    output logic [WORD-1:0]      inst_out,
    output logic [7:0]           ctrl_out,
    output logic [3*REG_LOG-1:0] rs_out,
    output logic [WORD-1:0]      result_out
);

    mem_state_e          state_q;
    logic [WORD-1:0]     ld_data_q;
    logic                is_load;
    logic                is_store;
    logic                is_mem;
    logic [1:0]          off;
    logic [2*WORD-1:0]   prod;
    logic [WORD-1:0]     ld_aligned;

    // EX leaves the middle partial product unshifted and signed.
    function automatic logic [2*WORD-1:0] mul_complete(input logic [3*WORD-1:0] t);
        logic signed [2*WORD-1:0] mid;
        mid = {{WORD{t[2*WORD-1]}}, t[2*WORD-1:WORD]};
        return {t[3*WORD-1:2*WORD], t[WORD-1:0]} + (mid <<< 16);
    endfunction

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        case (is_dmem_in)
            DMEM_LOAD:  is_load  = 1'b1;
            DMEM_STORE: is_store = 1'b1;
            DMEM_NONE:  ;
            default:    ;
        endcase
    end

    assign is_mem = is_load | is_store;
    assign off    = alu_res_in[1:0];
    assign prod   = mul_complete(mul_tmp_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= MEM_IDLE;
            ld_data_q <= '0;
        end else begin
            case (state_q)
                MEM_IDLE: if (is_mem) state_q <= dc.dc_addr_ok ? MEM_WAIT : MEM_REQ;
                MEM_REQ:  if (dc.dc_addr_ok) state_q <= MEM_WAIT;
                MEM_WAIT: if (dc.dc_data_ok) begin
                    ld_data_q <= dc.dc_rdata;
                    state_q   <= MEM_DONE;
                end
                MEM_DONE: state_q <= MEM_IDLE;
                default:  state_q <= MEM_IDLE;
            endcase
        end
    end

    // The request is raised in the op's first IDLE cycle so an immediate
    // addr_ok skips REQ entirely.
    assign dc.dc_req          = (state_q == MEM_IDLE && is_mem) || (state_q == MEM_REQ);
    assign stall_from_DCache  = dc.dc_req || (state_q == MEM_WAIT);
    assign dc.dc_we           = is_store;
    assign dc.dc_addr         = {alu_res_in[WORD-1:2], 2'b00};
    assign dc.dc_wstrb        = is_store ? store_strobe(io_info_in, off) : 4'b0000;

    always_comb begin
        case (io_info_in)
            IO_BYTE: dc.dc_wdata = {4{data_to_t_in[7:0]}};
            IO_HALF: dc.dc_wdata = {2{data_to_t_in[15:0]}};
            default: dc.dc_wdata = data_to_t_in;
        endcase
    end

    mem_load_align #(
        .WORD (WORD)
    ) u_load_align (
        .rdata_i (ld_data_q),
        .off_i   (off),
        .io_i    (io_info_in),
        .sign_i  (sign_in),
        .data_o  (ld_aligned)
    );

    always_comb begin
        if (is_load)
            result_out = ld_aligned;
        else if (is_store || !cal_sel_in)
            result_out = alu_res_in;
        else
            result_out = ctrl_in[0] ? prod[2*WORD-1:WORD] : prod[WORD-1:0];
    end

    assign pc_out   = pc_in;
    assign inst_out = inst_in;
    assign ctrl_out = ctrl_in;
    assign rs_out   = rs_in;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: the bench plays the DCache and predicts
// every output from a transaction-level model of the stage.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in, inst_in, alu_res_in, data_to_t_in;
    logic [7:0]  ctrl_in;
    logic        cal_sel_in, sign_in;
    logic [14:0] rs_in;
    logic [95:0] mul_tmp_in;
    logic [1:0]  is_dmem_in, io_info_in;
    logic        stall_from_DCache;
    logic [31:0] pc_out, inst_out, result_out;
    logic [7:0]  ctrl_out;
    logic [14:0] rs_out;

    int n_tests = 0;
    int n_fail  = 0;

    mem_stage_if dc_if ();

    mem_stage dut (
        .clk               (clk),
        .rst               (rst),
        .pc_in             (pc_in),
        .inst_in           (inst_in),
        .ctrl_in           (ctrl_in),
        .cal_sel_in        (cal_sel_in),
        .alu_res_in        (alu_res_in),
        .rs_in             (rs_in),
        .sign_in           (sign_in),
        .mul_tmp_in        (mul_tmp_in),
        .is_dmem_in        (is_dmem_in),
        .io_info_in        (io_info_in),
        .data_to_t_in      (data_to_t_in),
        .dc                (dc_if),
        .stall_from_DCache (stall_from_DCache),
        .pc_out            (pc_out),
        .inst_out          (inst_out),
        .ctrl_out          (ctrl_out),
        .rs_out            (rs_out),
        .result_out        (result_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the full 64-bit product from its three pieces.
    function automatic logic [31:0] ref_mul(input logic [31:0] h, m, l, input logic hi);
        logic [63:0] p;
        p = {h, l} + ({{32{m[31]}}, m} * 64'd65536);
        return hi ? p[63:32] : p[31:0];
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [1:0] off,
                                             input logic [1:0] io, input logic sgn);
        logic [31:0] v;
        if (io == 2'b00) begin
            v = (rd >> {off, 3'b000}) & 32'h0000_00FF;
            if (sgn && v[7]) v = v | 32'hFFFF_FF00;
        end else if (io == 2'b01) begin
            v = (off[1] ? (rd >> 16) : rd) & 32'h0000_FFFF;
            if (sgn && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // Byte lanes covered by an access of the given size at its aligned base.
    function automatic logic [3:0] ref_strb(input logic [1:0] io, input logic [1:0] off);
        int size, base;
        logic [3:0] s;
        size = (io == 2'b00) ? 1 : (io == 2'b01) ? 2 : 4;
        base = int'(off) & ~(size - 1);
        for (int b = 0; b < 4; b++) s[b] = (b >= base) && (b < base + size);
        return s;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] io, input logic [31:0] d);
        if (io == 2'b00) return {24'b0, d[7:0]} * 32'h0101_0101;
        if (io == 2'b01) return {16'b0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    task automatic randomize_passthrough();
        pc_in      = $urandom;
        inst_in    = $urandom;
        ctrl_in    = 8'($urandom);
        rs_in      = 15'($urandom);
        mul_tmp_in = {$urandom, $urandom, $urandom};
    endtask

    // Non-memory op: everything settles in the same cycle with no stall.
    task automatic do_alu(input string tag, input logic [31:0] exp);
        @(negedge clk);
        check({tag, "_stall"}, 32'(stall_from_DCache), 32'd0);
        check({tag, "_req"}, 32'(dc_if.dc_req), 32'd0);
        check({tag, "_res"}, result_out, exp);
        step();
    endtask

    task automatic do_mem(input logic st, input logic [1:0] io, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] rdata, input int aok_dly, input int dok_dly);
        logic [31:0] exp_res;
        randomize_passthrough();
        is_dmem_in   = st ? 2'b10 : 2'b01;
        io_info_in   = io;
        sign_in      = sgn;
        alu_res_in   = addr;
        data_to_t_in = data;
        cal_sel_in   = 1'($urandom_range(0, 1));
        exp_res      = st ? addr : ref_load(rdata, addr[1:0], io, sgn);
        for (int i = 0; i <= aok_dly; i++) begin
            dc_if.dc_addr_ok = (i == aok_dly);
            dc_if.dc_data_ok = (i != aok_dly) ? 1'($urandom_range(0, 1)) : 1'b0;
            dc_if.dc_rdata   = $urandom;
            @(negedge clk);
            check("req_hi", 32'(dc_if.dc_req), 32'd1);
            check("req_stall", 32'(stall_from_DCache), 32'd1);
            check("addr", dc_if.dc_addr, addr & 32'hFFFF_FFFC);
            check("we", 32'(dc_if.dc_we), 32'(st));
            check("wstrb", 32'(dc_if.dc_wstrb), st ? 32'(ref_strb(io, addr[1:0])) : 32'd0);
            if (st) check("wdata", dc_if.dc_wdata, ref_wdata(io, data));
            step();
        end
        dc_if.dc_addr_ok = 1'b0;
        for (int j = 1; j <= dok_dly; j++) begin
            dc_if.dc_data_ok = (j == dok_dly);
            dc_if.dc_rdata   = (j == dok_dly) ? rdata : $urandom;
            @(negedge clk);
            check("wait_req", 32'(dc_if.dc_req), 32'd0);
            check("wait_stall", 32'(stall_from_DCache), 32'd1);
            step();
        end
        dc_if.dc_data_ok = 1'b0;
        dc_if.dc_rdata   = $urandom;
        @(negedge clk);
        check("done_stall", 32'(stall_from_DCache), 32'd0);
        check("done_req", 32'(dc_if.dc_req), 32'd0);
        check("done_res", result_out, exp_res);
        check("done_pc", pc_out, pc_in);
        step();
        is_dmem_in = 2'b00;
    endtask

    // The captured load word is only visible through result_out of a load.
    task automatic check_ld_zero(input string tag);
        is_dmem_in = 2'b01;
        io_info_in = 2'b10;
        alu_res_in = 32'h0;
        #1;
        check(tag, result_out, 32'h0);
        is_dmem_in = 2'b00;
    endtask

    initial begin
        rst = 1'b1;
        randomize_passthrough();
        cal_sel_in = 1'b0; sign_in = 1'b0; alu_res_in = 32'h0; data_to_t_in = 32'h0;
        is_dmem_in = 2'b00; io_info_in = 2'b00;
        dc_if.dc_addr_ok = 1'b0; dc_if.dc_data_ok = 1'b0; dc_if.dc_rdata = 32'h0;
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_req", 32'(dc_if.dc_req), 32'd0);
        check("rst_stall", 32'(stall_from_DCache), 32'd0);
        check_ld_zero("rst_lddata");
        step();

        alu_res_in = 32'h1234_5678; cal_sel_in = 1'b0;
        do_alu("alu", 32'h1234_5678);
        cal_sel_in = 1'b1; ctrl_in = 8'h00; mul_tmp_in = {32'h0, 32'h1, 32'h1};
        do_alu("mul_lo", 32'h0001_0001);
        ctrl_in = 8'h01; mul_tmp_in = {32'h2, 32'hFFFF_FFFF, 32'h0};
        do_alu("mul_hi", 32'h0000_0001);

        for (int k = 0; k < 40; k++) begin
            randomize_passthrough();
            alu_res_in = $urandom;
            cal_sel_in = 1'($urandom_range(0, 1));
            is_dmem_in = $urandom_range(0, 1) ? 2'b11 : 2'b00;
            dc_if.dc_addr_ok = 1'($urandom_range(0, 1));
            dc_if.dc_data_ok = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("rnd_pc", pc_out, pc_in);
            check("rnd_inst", inst_out, inst_in);
            check("rnd_ctrl", 32'(ctrl_out), 32'(ctrl_in));
            check("rnd_rs", 32'(rs_out), 32'(rs_in));
            do_alu("rnd", cal_sel_in ? ref_mul(mul_tmp_in[95:64], mul_tmp_in[63:32],
                                               mul_tmp_in[31:0], ctrl_in[0]) : alu_res_in);
        end
        dc_if.dc_addr_ok = 1'b0; dc_if.dc_data_ok = 1'b0;

        do_mem(1'b0, 2'b00, 1'b1, 32'h1000_0003, 32'h0, 32'h80FF_FFFF, 0, 2);
        do_mem(1'b0, 2'b00, 1'b0, 32'h1000_0003, 32'h0, 32'h80FF_FFFF, 0, 2);
        do_mem(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'hABCD_1234, 32'h0, 3, 1);
        do_mem(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'h1357_9BDF, 1, 1);
        do_mem(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 32'h8001_7FFF, 0, 1);

        for (int k = 0; k < 30; k++) begin
            do_mem(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 3));
        end

        do_mem(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 0, 1);
        randomize_passthrough();
        is_dmem_in = 2'b01; io_info_in = 2'b10; alu_res_in = 32'h0000_0044;
        dc_if.dc_addr_ok = 1'b1;
        @(negedge clk);
        check("rw_req", 32'(dc_if.dc_req), 32'd1);
        step();
        dc_if.dc_addr_ok = 1'b0;
        rst = 1'b1; is_dmem_in = 2'b00;
        @(negedge clk);
        check("rw_wait_stall", 32'(stall_from_DCache), 32'd1);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rw_stall", 32'(stall_from_DCache), 32'd0);
        check("rw_req0", 32'(dc_if.dc_req), 32'd0);
        check_ld_zero("rw_lddata");
        step();

        do_mem(1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'h0, 32'h2468_ACE0, 2, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

endmodule
